rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one downstream resource (e.g. a 2-to-4 decoded select bus) among 4 requesters.
- Registers a one-hot grant plus a 2-bit grant index for driving a 2-to-4 decoder/mux.
- Enforces fairness via a rotating priority pointer and a maximum hold time.
- Sits between requesting masters and the shared datapath select logic.

Parameters:
- MAX_HOLD, 8, max consecutive cycles one owner keeps the grant while others wait (legal range 1..255).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  level request per requester, bit i = requester i.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- gnt_idx  output  2  binary index of current owner; 0 when idle.
- gnt_valid  output  1  high when any grant is active (equals OR of gnt).
- grant_cnt  output  8  total grants issued; present only with ARB_GRANT_CNT_EN.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset:
  - gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE, ptr=0, hold_cnt=0.
  - grant_cnt=0 when present.
  - Asserting rst_n mid-grant clears the grant immediately, with no clock needed.
- States:
  - IDLE: no owner.
  - BUSY: one owner holds gnt.
- Pick function: first requester with req set, scanning ptr, ptr+1, … with mod-4 wrap.
- IDLE transitions:
  - req==0: stay in IDLE.
  - Otherwise: on the next edge, grant the pick, go to BUSY, hold_cnt=1, ptr=winner+1 mod 4.
  - Latency from req to gnt is 1 cycle.
- BUSY, owner still requesting (req[owner]=1):
  - hold_cnt<MAX_HOLD: keep the grant, hold_cnt++.
  - hold_cnt==MAX_HOLD and another req pending: hand over to the pick (ptr already past owner) on the same edge, with no idle cycle; hold_cnt=1.
  - hold_cnt==MAX_HOLD and no other req pending: keep the grant, hold_cnt=1 (restart the window).
- BUSY, owner releases (req[owner]=0):
  - gnt deasserts on the next edge.
  - If other requests are pending, the grant moves directly to the pick on that same edge.
  - Otherwise go to IDLE.
- A requester is never granted in two consecutive tenures while another requester is pending.
- Simultaneous requests: resolved solely by ptr; no fixed priority.
- Pointer wrap: ptr is 2 bits; 3+1 wraps to 0.
- Outputs are always one-hot or zero; gnt_idx and gnt are updated in the same register stage.
- MAX_HOLD=1: the grant rotates every cycle while there is contention.

Optional Feature:
- Macro: ARB_GRANT_CNT_EN.
- Defined:
  - grant_cnt port present.
  - Increments by 1 on every edge that starts a new tenure: IDLE->BUSY, handover, or the re-grant after a timeout with no other requester.
  - Wraps 255->0.
- Undefined: port and counter are absent; all other behaviour is unchanged.

Decomposition:
- Package arb_pkg:
  - N_REQ=4, IDX_W=2, CNT_W=8.
  - State encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1.
- Sub-module arb_pick_rr: combinational rotate-priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: pick_idx[1:0], pick_any.
  - Instantiated once in rr_arbiter_4.

Test Plan:
- Reset mid-grant:
  - Stimulus: req=4'b0010 for 3 cycles, then pull rst_n low asynchronously.
  - Required: gnt=0, gnt_valid=0 immediately (before the next clk); after release with req=0, stays idle.
- Single request:
  - Stimulus: req=4'b0100 from idle.
  - Required: one cycle later gnt=4'b0100, gnt_idx=2; after dropping req, gnt=0 on the next edge.
- Simultaneous requests, round-robin order:
  - Stimulus: req=4'b1111 continuously, each owner dropping its req after 2 cycles then re-raising.
  - Required: grant order 0,1,2,3,0 with no idle cycles between handovers.
- Hold timeout (MAX_HOLD=8):
  - Stimulus: req[0] held high, req[3] raised at cycle 2.
  - Required: requester 0 granted exactly 8 cycles, then gnt=4'b1000 on the next edge.
- Timeout without contention:
  - Stimulus: only req[1] held high for 20 cycles.
  - Required: gnt=4'b0010 stays asserted throughout; grant_cnt (with ARB_GRANT_CNT_EN) reads 3 after 17 grant cycles.
- Counter wrap (with ARB_GRANT_CNT_EN):
  - Stimulus: 256 single-cycle tenures.
  - Required: grant_cnt returns to 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/arb_pick_rr.sv
// Rotating-priority picker: returns the first set request scanning ptr, ptr+1, ... mod 4.
module arb_pick_rr
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    logic [IDX_W-1:0] cand [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = ptr + IDX_W'(gi);
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        pick_idx = '0;
        pick_any = 1'b0;
        for (int o = N_REQ - 1; o >= 0; o--) begin
            if (req[cand[o]]) begin
                pick_idx = cand[o];
                pick_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with hold-time limit and registered grant outputs.
// Optional grant counter output enabled by defining ARB_GRANT_CNT_EN.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] grant_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             others_pending;
    logic             hold_expired;
    logic             take_pick;
    logic             regrant;
    logic             go_idle;

    arb_pick_rr u_pick (
        .req      (req),
        .ptr      (ptr),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    assign owner_req      = |(req & gnt);
    assign others_pending = |(req & ~gnt);
    assign hold_expired   = (hold_cnt >= MAX_HOLD_C);

    // ptr already points past the owner, so a pick taken while others wait never re-selects it.
    always_comb begin
        take_pick = 1'b0;
        regrant   = 1'b0;
        go_idle   = 1'b0;
        if (state == ST_IDLE) begin
            take_pick = pick_any;
        end else if (owner_req) begin
            take_pick = hold_expired && others_pending;
            regrant   = hold_expired && !others_pending;
        end else begin
            take_pick = pick_any;
            go_idle   = !pick_any;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else if (take_pick) begin
            state     <= ST_BUSY;
            ptr       <= pick_idx + IDX_W'(1);
            hold_cnt  <= CNT_W'(1);
            gnt       <= idx2onehot(pick_idx);
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
        end else if (regrant) begin
            hold_cnt  <= CNT_W'(1);
        end else if (go_idle) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else if (state == ST_BUSY) begin
            hold_cnt  <= hold_cnt + CNT_W'(1);
        end
    end

`ifdef ARB_GRANT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (take_pick || regrant) begin
            grant_cnt <= grant_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4 (MAX_HOLD=8); counter checks need ARB_GRANT_CNT_EN.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
`ifdef ARB_GRANT_CNT_EN
    logic [7:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rr_arbiter_4 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_gnt;
        logic [1:0] exp_idx;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    task automatic check_gnt(input string name, input logic [3:0] eg,
                             input logic [1:0] ei, input logic ev);
        check({name, ".gnt"}, int'(gnt), int'(eg));
        check({name, ".idx"}, int'(gnt_idx), int'(ei));
        check({name, ".valid"}, int'(gnt_valid), int'(ev));
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [3:0] oh;

        // Expected values hand-derived from ptr=0 after reset.
        vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[4]  = '{4'b1111, 4'b1000, 2'd3, 1'b1};
        vecs[5]  = '{4'b0111, 4'b0001, 2'd0, 1'b1};
        vecs[6]  = '{4'b0110, 4'b0010, 2'd1, 1'b1};
        vecs[7]  = '{4'b1101, 4'b0100, 2'd2, 1'b1};
        vecs[8]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};
        vecs[9]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[10] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[11] = '{4'b0011, 4'b0010, 2'd1, 1'b1};
        vecs[12] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[13] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

        req   = 4'b0000;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_gnt("reset", 4'b0000, 2'd0, 1'b0);
`ifdef ARB_GRANT_CNT_EN
        check("reset.grant_cnt", int'(grant_cnt), 0);
`endif
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            req = vecs[i].req;
            step();
            check_gnt($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_idx, vecs[i].exp_valid);
        end

        // Reset asserted mid-grant must clear outputs without a clock.
        do_reset();
        req = 4'b0010;
        repeat (3) step();
        check_gnt("pre_rst", 4'b0010, 2'd1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_gnt("async_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b0000;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) step();
        check_gnt("post_rst_idle", 4'b0000, 2'd0, 1'b0);

        // All requesting; each owner drops after 2 cycles: order 0,1,2,3,0, never idle.
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            check_gnt($sformatf("rr%0d.first", k), oh, 2'(k % 4), 1'b1);
            req = 4'b1111;
            step();
            check_gnt($sformatf("rr%0d.second", k), oh, 2'(k % 4), 1'b1);
            req = 4'b1111 & ~oh;
            step();
        end
        check_gnt("rr_after", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        step();

        // Hold timeout: requester 0 keeps exactly 8 cycles, then hands to 3.
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 2) req = 4'b1001;
            check($sformatf("hold.c%0d", c), int'(gnt), 1);
        end
        step();
        check_gnt("hold.handover", 4'b1000, 2'd3, 1'b1);
        req = 4'b0000;
        step();

        // Timeout without contention: grant stays; counter shows the window restarts.
        do_reset();
        req = 4'b0010;
        for (int c = 1; c <= 20; c++) begin
            step();
            check($sformatf("solo.c%0d", c), int'(gnt), 2);
`ifdef ARB_GRANT_CNT_EN
            if (c == 8)  check("solo.cnt8",  int'(grant_cnt), 1);
            if (c == 9)  check("solo.cnt9",  int'(grant_cnt), 2);
            if (c == 17) check("solo.cnt17", int'(grant_cnt), 3);
`endif
        end
        req = 4'b0000;
        step();

`ifdef ARB_GRANT_CNT_EN
        // 256 single-cycle tenures wrap the counter back to zero.
        do_reset();
        for (int t = 1; t <= 256; t++) begin
            req = 4'b0001;
            step();
            req = 4'b0000;
            step();
            if (t == 255) check("wrap.cnt255", int'(grant_cnt), 255);
        end
        check("wrap.cnt0", int'(grant_cnt), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
